// File: rtl/mac_stream_sequencer.sv
// Job sequencer for a registered mac_unit: pulls operand pairs, chains each MAC
// result back as the next accumulator operand and reports the final sum.
module mac_stream_sequencer #(
    parameter int MAX_LEN     = 64,
    parameter int MAC_LATENCY = 1,
    parameter int LW          = $clog2(MAX_LEN + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [LW-1:0] len_i,
    input  logic [1:0]    mode_i,
    input  logic          saturate_i,
    input  logic          round_i,
    input  logic [31:0]   acc_init_i,
    output logic          busy_o,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [31:0]   in_a_i,
    input  logic [31:0]   in_b_i,
    output logic          mac_enable_o,
    output logic [31:0]   mac_a_o,
    output logic [31:0]   mac_b_o,
    output logic [31:0]   mac_c_o,
    output logic [1:0]    mac_mode_o,
    output logic          mac_saturate_o,
    output logic          mac_round_o,
    input  logic [31:0]   mac_result_i,
    input  logic          mac_overflow_i,
    input  logic          mac_underflow_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [31:0]   out_result_o,
    output logic          out_overflow_o,
    output logic          out_underflow_o,
    output logic [LW-1:0] out_count_o
);

    localparam int WW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = WW'(MAC_LATENCY - 1);
    localparam logic [LW-1:0] MAX_LEN_W = LW'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] tapCnt_q;
    logic [31:0]   acc_q;
    logic [WW-1:0] waitCnt_q;
    logic          ovf_q;
    logic          unf_q;
    logic          busy_q;
    logic          inReady_q;
    logic          outValid_q;
    logic [1:0]    mode_q;
    logic          sat_q;
    logic          rnd_q;

    logic [LW-1:0] lenClamped_d;
    logic [LW-1:0] tapCnt_d;
    logic          issue;

    assign lenClamped_d = (len_i > MAX_LEN_W) ? MAX_LEN_W : len_i;
    assign tapCnt_d     = tapCnt_q + LW'(1);
    assign issue        = inReady_q & in_valid_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            tapCnt_q   <= '0;
            acc_q      <= '0;
            waitCnt_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            busy_q     <= 1'b0;
            inReady_q  <= 1'b0;
            outValid_q <= 1'b0;
            mode_q     <= '0;
            sat_q      <= 1'b0;
            rnd_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        len_q    <= lenClamped_d;
                        mode_q   <= mode_i;
                        sat_q    <= saturate_i;
                        rnd_q    <= round_i;
                        acc_q    <= acc_init_i;
                        ovf_q    <= 1'b0;
                        unf_q    <= 1'b0;
                        tapCnt_q <= '0;
                        busy_q   <= 1'b1;
                        if (lenClamped_d != '0) begin
                            state_q   <= S_ISSUE;
                            inReady_q <= 1'b1;
                        end else begin
                            state_q    <= S_DONE;
                            outValid_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        inReady_q <= 1'b0;
                        waitCnt_q <= WAIT_LOAD;
                        state_q   <= S_WAIT;
                    end
                end
                // The MAC result is only trusted on the final WAIT cycle.
                S_WAIT: begin
                    if (waitCnt_q != '0) begin
                        waitCnt_q <= waitCnt_q - WW'(1);
                    end else begin
                        acc_q    <= mac_result_i;
                        ovf_q    <= ovf_q | mac_overflow_i;
                        unf_q    <= unf_q | mac_underflow_i;
                        tapCnt_q <= tapCnt_d;
                        if (tapCnt_d == len_q) begin
                            state_q    <= S_DONE;
                            outValid_q <= 1'b1;
                        end else begin
                            state_q   <= S_ISSUE;
                            inReady_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        state_q    <= S_IDLE;
                        outValid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        mode_q     <= '0;
                        sat_q      <= 1'b0;
                        rnd_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign in_ready_o      = inReady_q;
    assign mac_enable_o    = issue;
    assign mac_a_o         = issue ? in_a_i : '0;
    assign mac_b_o         = issue ? in_b_i : '0;
    assign mac_c_o         = issue ? acc_q : '0;
    assign mac_mode_o      = mode_q;
    assign mac_saturate_o  = sat_q;
    assign mac_round_o     = rnd_q;
    assign out_valid_o     = outValid_q;
    // Result buses read as zero whenever no job result is being offered.
    assign out_result_o    = outValid_q ? acc_q : '0;
    assign out_overflow_o  = outValid_q & ovf_q;
    assign out_underflow_o = outValid_q & unf_q;
    assign out_count_o     = outValid_q ? tapCnt_q : '0;

endmodule

// File: doc/mac_stream_sequencer.md
# mac_stream_sequencer

Initiator-side controller for the registered `mac_unit` multiply-accumulate datapath. It accepts a job descriptor:
- tap count
- arithmetic mode
- saturate and round flags
- initial accumulator value

It then pulls operand pairs from a valid/ready stream and drives the MAC one operation at a time. Each MAC result is fed back as the next `c` operand. When the job finishes, it presents the final accumulated value, sticky overflow/underflow flags and the tap count on a valid/ready output. It sits between the DSP operand fetch logic and `mac_unit`, turning the MAC into a dot-product / FIR-tap engine.

## Interface
- `MAX_LEN`, 64: maximum taps per job.
- `MAC_LATENCY`, 1: cycles from a MAC issue (`mac_enable` high) to a valid `mac_result`; must be ≥1.
- `LW`, `$clog2(MAX_LEN+1)`: tap-count width.

Ports:
- `clk`  in  1  clock, rising edge only.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  job request, sampled in IDLE only.
- `len`  in  LW  tap count; values > `MAX_LEN` are clamped to `MAX_LEN`.
- `mode`  in  2  MAC mode: 00 signed, 01 unsigned, 10 mixed.
- `saturate`, `round`  in  1 each  MAC options.
- `acc_init`  in  32  initial accumulator value.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  operand pair accepted.
- `in_a`, `in_b`  in  32 each  operands.
- `mac_enable`  out  1  MAC issue strobe.
- `mac_a`, `mac_b`, `mac_c`  out  32 each  MAC operands.
- `mac_mode`  out  2  MAC mode.
- `mac_saturate`, `mac_round`  out  1 each  MAC options.
- `mac_result`  in  32  MAC result.
- `mac_overflow`, `mac_underflow`  in  1 each  MAC status flags.
- `out_valid`  in/out: out  1  job result valid.
- `out_ready`  in  1  consumer ready.
- `out_result`  out  32  final accumulator.
- `out_overflow`, `out_underflow`  out  1 each  sticky OR of MAC flags over the job.
- `out_count`  out  LW  taps actually executed.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - If `start`=1: latch `len` (clamped), `mode`, `saturate`, `round`; load `acc`←`acc_init`; clear the sticky flags and the tap counter.
  - Next state: ISSUE if the clamped length is > 0, otherwise DONE.
  - `start` in any other state is ignored.
- **ISSUE:**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, in the same cycle: `mac_enable`=1, `mac_a`=`in_a`, `mac_b`=`in_b`, `mac_c`=`acc`. Next state is WAIT.
  - With no `in_valid`, remain in ISSUE, with `mac_enable`=0 and the MAC operand buses at 0.
- **WAIT:**
  - Lasts `MAC_LATENCY` cycles, counted by a down-counter.
  - On the last WAIT cycle: `acc`←`mac_result`; sticky flags |= `mac_overflow`/`mac_underflow`; tap counter increments.
  - Then go to DONE if the tap counter reaches the latched length, otherwise back to ISSUE.
- **DONE:**
  - `out_valid`=1; `out_result`=`acc`; `out_count`=tap counter; flags driven from the sticky registers.
  - On `out_valid`&`out_ready`, go to IDLE.
- `mac_mode`, `mac_saturate` and `mac_round` drive the latched job configuration, constant for the whole job. In IDLE they are 0.
- The sequencer never modifies arithmetic. Width, saturation and rounding are owned by `mac_unit`, and `acc` is exactly the last `mac_result`.

## Timing
- **Reset values:** every output is 0 (`busy`, `in_ready`, `mac_*`, `out_*`). The state is IDLE and `acc` is 0.
- **Reset mid-job:** reset in any state aborts the job on the next edge. No `out_valid` is produced for the aborted job, and any pending MAC result is ignored.
- **Handshakes:** a transfer occurs on a rising edge where valid & ready. `out_result`, `out_count` and the flags are stable while `out_valid`=1 and `out_ready`=0.
- **Issue rate:** one operand pair per `MAC_LATENCY`+1 cycles at most. `mac_enable` is never high on two cycles closer together than that.
- **Job latency (no stalls):**
  - Start sampled at edge 0.
  - For N taps, `out_valid` first rises in cycle N·(`MAC_LATENCY`+1)+1.
  - For N=0, `out_valid` rises in cycle 1.
- **Input stalls:** each cycle in ISSUE without `in_valid` adds one cycle.
- **Back-to-back jobs:** after the output handshake the block is in IDLE for one cycle, where `start` may be sampled.

## Test plan
Use a behavioural MAC model that honours `MAC_LATENCY`.

1. **Basic accumulation:** `len`=3, `mode`=00, `acc_init`=0, pairs (0x1000,2), (0x1000,3), (1,1), `MAC_LATENCY`=1, `in_valid` held high.
   - Required: `out_valid` in cycle 7 after start; `out_result`=0x00005001; `out_count`=3; both flags 0.
2. **Backpressure and ignored start:** the same job with `in_valid` low for 2 cycles before each pair, `out_ready` held low for 5 cycles in DONE, and `start` pulsed during WAIT and during DONE.
   - Required: `out_valid` in cycle 13; `out_result` stable throughout the stall; no second job launched.
3. **Empty job:** `len`=0, `acc_init`=0x00001234.
   - Required: `out_valid` in cycle 1; `out_result`=0x00001234; `out_count`=0; `mac_enable` never asserted.
4. **Sticky flags and config passthrough:** `len`=2, `saturate`=1, pairs (0x7FFFFFFF,2) then (0,0), with the model flagging overflow on the first operation.
   - Required: `out_overflow`=1 at DONE; `mac_saturate`=1 on both issues.
5. **Reset mid-job:** `rst_n` low during the WAIT of tap 2 of a 4-tap job.
   - Required: all outputs 0 on the following cycle.
   - A fresh 1-tap job (-1)·(-1), `mode`=00, then yields `out_result`=0x00000001.
6. **Long latency and clamping:** `MAC_LATENCY`=3, `len`=MAX_LEN+5.
   - Required: `out_count`=`MAX_LEN`; `mac_enable` spacing exactly 4 cycles; `out_valid` in cycle 4·`MAX_LEN`+1.
